wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 17 +
 rtl/wb_arbiter_rr_pick2.sv | 19 +
 rtl/wb_arbiter.sv | 158 +++++++++++++++
 tb/tb_wb_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared SoC Wishbone bus package: default widths, abort limit
// and the arbiter ownership encoding.
package wb_arbiter_pkg;

  localparam int WB_AW      = 32;
  localparam int WB_DW      = 32;
  localparam int WB_TIMEOUT = 255;
  localparam int WB_WAIT_W  = 16;

  // One-hot so the state register doubles as the grant vector
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } arb_state_e;

endpackage

// File: rtl/wb_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the master
// not granted last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter (m0 fetch, m1 data) with
// locked ownership, round-robin ties and slave timeout.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int TIMEOUT = WB_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      gnt_o,
  output logic            to_o
);

  localparam logic [WB_WAIT_W-1:0] TO_CNT =
    WB_WAIT_W'(TIMEOUT);

  arb_state_e           r_state;
  arb_state_e           w_next;
  logic                 r_last;
  logic [WB_WAIT_W-1:0] r_wait;
  logic                 w_own0;
  logic                 w_own1;
  logic                 w_ocyc;
  logic                 w_resp;
  logic                 w_to;
  logic [1:0]           w_pick;

  assign w_own0 = (r_state == ST_OWN0);
  assign w_own1 = (r_state == ST_OWN1);
  assign w_ocyc = (w_own0 & m0_cyc_i)
                | (w_own1 & m1_cyc_i);
  assign w_resp = s_ack_i | s_err_i;
  // A response in the limit cycle beats the abort
  assign w_to   = w_ocyc & ~w_resp
                & (r_wait == TO_CNT);

  rr_pick2 u_pick (
    .req   ({m1_cyc_i, m0_cyc_i}),
    .last  (r_last),
    .grant (w_pick)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_OWN0: begin
        if (w_to)
          w_next = ST_IDLE;
        else if (!m0_cyc_i)
          w_next = m1_cyc_i ? ST_OWN1 : ST_IDLE;
      end
      ST_OWN1: begin
        if (w_to)
          w_next = ST_IDLE;
        else if (!m1_cyc_i)
          w_next = m0_cyc_i ? ST_OWN0 : ST_IDLE;
      end
      default: begin
        unique case (1'b1)
          w_pick[0]: w_next = ST_OWN0;
          w_pick[1]: w_next = ST_OWN1;
          default:   w_next = ST_IDLE;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == ST_OWN0)
        r_last <= 1'b0;
      else if (w_next == ST_OWN1)
        r_last <= 1'b1;
      if (w_next != r_state || w_next == ST_IDLE
          || w_resp)
        r_wait <= '0;
      else if (s_stb_o)
        r_wait <= r_wait + 16'd1;
    end
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (w_own0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
    end else if (w_own1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
    end
    if (w_to) begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
    end
  end

  // Responses go only to an owner still holding cyc
  assign m0_ack_o = w_own0 & m0_cyc_i
                  & s_ack_i & ~s_err_i;
  assign m0_err_o = w_own0 & m0_cyc_i
                  & (s_err_i | w_to);
  assign m1_ack_o = w_own1 & m1_cyc_i
                  & s_ack_i & ~s_err_i;
  assign m1_err_o = w_own1 & m1_cyc_i
                  & (s_err_i | w_to);
  assign m0_dat_o = w_own0 ? s_dat_i : '0;
  assign m1_dat_o = w_own1 ? s_dat_i : '0;
  assign gnt_o    = r_state;
  assign to_o     = w_to;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench: directed vector table, async reset
// sequence and randomized traffic against an owner model.
module tb_wb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [AW-1:0] m0_adr = '0;
  logic [DW-1:0] m0_dat = '0;
  logic [3:0]    m0_sel = '0;
  logic          m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [AW-1:0] m1_adr = '0;
  logic [DW-1:0] m1_dat = '0;
  logic [3:0]    m1_sel = '0;
  logic [DW-1:0] m0_dato, m1_dato;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dato;
  logic [3:0]    s_sel;
  logic [DW-1:0] s_dati = '0;
  logic          s_ack = 0, s_err = 0;
  logic [1:0]    gnt;
  logic          to;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
    .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel),
    .m0_dat_o(m0_dato), .m0_ack_o(m0_ack),
    .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
    .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel),
    .m1_dat_o(m1_dato), .m1_ack_o(m1_ack),
    .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_dat_o(s_dato),
    .s_sel_o(s_sel), .s_dat_i(s_dati),
    .s_ack_i(s_ack), .s_err_i(s_err),
    .gnt_o(gnt), .to_o(to)
  );

  task automatic check(input string nm,
                       input logic [191:0] act,
                       input logic [191:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  typedef struct {
    bit          r;
    bit [5:0]    in;   // c0 s0 c1 s1 ack err
    logic [31:0] rd;
    logic [1:0]  g;
    bit [1:0]    cs;   // s_cyc s_stb
    logic [31:0] sa;
    bit [4:0]    rsp;  // a0 a1 e0 e1 to
    logic [31:0] d0;
    logic [31:0] d1;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit r, input bit [5:0] in,
                     input logic [31:0] rd,
                     input logic [1:0] g,
                     input bit [1:0] cs,
                     input logic [31:0] sa,
                     input bit [4:0] rsp,
                     input logic [31:0] d0,
                     input logic [31:0] d1);
    vec_t v;
    v.r = r; v.in = in; v.rd = rd; v.g = g;
    v.cs = cs; v.sa = sa; v.rsp = rsp;
    v.d0 = d0; v.d1 = d1;
    vq.push_back(v);
  endtask

  function automatic logic [191:0] pk_act();
    return 192'({gnt, to, s_cyc, s_stb, s_we, s_adr,
                 s_dato, s_sel, m0_ack, m0_err, m0_dato,
                 m1_ack, m1_err, m1_dato});
  endfunction

  // Reference model: who owns the bus, who won last,
  // and how long the current strobe has gone unanswered.
  int own = -1, last = 1, wcnt = 0;
  int n_own, n_last, n_wcnt;

  task automatic model_eval(output logic [191:0] e);
    bit          cyc[2], stb[2], we[2];
    logic [31:0] adr[2], dat[2];
    logic [3:0]  sel[2];
    bit          ak[2], er[2];
    logic [31:0] dq[2];
    bit          route, resp, tmo, has;
    logic [1:0]  g;
    int          o, oth;
    cyc = '{m0_cyc, m1_cyc}; stb = '{m0_stb, m1_stb};
    we  = '{m0_we, m1_we};   adr = '{m0_adr, m1_adr};
    dat = '{m0_dat, m1_dat}; sel = '{m0_sel, m1_sel};
    has   = (own >= 0);
    o     = has ? own : 0;
    route = has && cyc[o];
    resp  = s_ack || s_err;
    tmo   = route && (wcnt == TO) && !resp;
    g     = !has ? 2'b00 : (o == 0 ? 2'b01 : 2'b10);
    for (int n = 0; n < 2; n++) begin
      ak[n] = has && o == n && route && s_ack && !s_err;
      er[n] = has && o == n && route && (s_err || tmo);
      dq[n] = (has && o == n) ? s_dati : 32'h0;
    end
    e = 192'({g, tmo,
              has && cyc[o] && !tmo,
              has && stb[o] && !tmo,
              has && we[o],
              has ? adr[o] : 32'h0,
              has ? dat[o] : 32'h0,
              has ? sel[o] : 4'h0,
              ak[0], er[0], dq[0],
              ak[1], er[1], dq[1]});
    n_own = own; n_last = last; n_wcnt = wcnt;
    if (tmo) begin
      n_own = -1; n_wcnt = 0;
    end else if (route) begin
      if (resp) n_wcnt = 0;
      else if (stb[o]) n_wcnt = wcnt + 1;
    end else begin
      if (has) begin
        oth   = 1 - o;
        n_own = cyc[oth] ? oth : -1;
      end else if (cyc[0] && cyc[1]) n_own = 1 - last;
      else if (cyc[0]) n_own = 0;
      else if (cyc[1]) n_own = 1;
      else n_own = -1;
      if (n_own >= 0) n_last = n_own;
      n_wcnt = 0;
    end
  endtask

  localparam logic [31:0] A = 32'h100;
  localparam logic [31:0] B = 32'h200;

  initial begin
    logic [191:0] e;
    bit           slow;

    // single m0 read, late ack after release
    add(0, 6'b110000, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    add(0, 6'b110000, 0, 2'b01, 2'b11, A, 0, 0, 0);
    add(0, 6'b110000, 0, 2'b01, 2'b11, A, 0, 0, 0);
    add(0, 6'b110010, 32'hDEADBEEF, 2'b01, 2'b11, A,
        5'b10000, 32'hDEADBEEF, 0);
    add(0, 6'b000010, 0, 2'b01, 2'b00, A, 0, 0, 0);
    add(0, 6'b000000, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    // two ties after reset alternate m0 then m1
    add(1, 6'b000000, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    add(0, 6'b111100, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    add(0, 6'b111110, 32'h11111111, 2'b01, 2'b11, A,
        5'b10000, 32'h11111111, 0);
    add(0, 6'b000000, 0, 2'b01, 2'b00, A, 0, 0, 0);
    add(0, 6'b111100, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    add(0, 6'b111110, 32'h22222222, 2'b10, 2'b11, B,
        5'b01000, 0, 32'h22222222);
    add(0, 6'b000000, 0, 2'b10, 2'b00, B, 0, 0, 0);
    // m1 locked burst, m0 handed over with no bubble
    add(0, 6'b001100, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(0, 6'b111110, 32'h33, 2'b10, 2'b11, B,
          5'b01000, 0, 32'h33);
    add(0, 6'b110000, 0, 2'b10, 2'b00, B, 0, 0, 0);
    add(0, 6'b110010, 32'h44, 2'b01, 2'b11, A,
        5'b10000, 32'h44, 0);
    add(0, 6'b000000, 0, 2'b01, 2'b00, A, 0, 0, 0);
    // silent slave -> abort
    add(0, 6'b110000, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < TO; i++)
      add(0, 6'b110000, 0, 2'b01, 2'b11, A, 0, 0, 0);
    add(0, 6'b110000, 0, 2'b01, 2'b00, A,
        5'b00101, 0, 0);
    add(0, 6'b000000, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    // ack+err together -> err only
    add(0, 6'b001100, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    add(0, 6'b001111, 32'h55, 2'b10, 2'b11, B,
        5'b00010, 0, 32'h55);
    add(0, 6'b000000, 0, 2'b10, 2'b00, B, 0, 0, 0);
    // ack in the limit cycle wins
    add(0, 6'b110000, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < TO; i++)
      add(0, 6'b110000, 0, 2'b01, 2'b11, A, 0, 0, 0);
    add(0, 6'b110010, 32'h66, 2'b01, 2'b11, A,
        5'b10000, 32'h66, 0);
    add(0, 6'b000000, 0, 2'b01, 2'b00, A, 0, 0, 0);
    add(0, 6'b000000, 0, 2'b00, 2'b00, 0, 0, 0, 0);

    m0_adr = A;
    m1_adr = B;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 192'({gnt, to, s_cyc, s_stb, m0_ack,
                         m0_err, m1_ack, m1_err}),
          192'(0));

    foreach (vq[i]) begin
      rst = vq[i].r;
      {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err}
        = vq[i].in;
      s_dati = vq[i].rd;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            192'({gnt, s_cyc, s_stb, s_adr, m0_ack,
                  m1_ack, m0_err, m1_err, to,
                  m0_dato, m1_dato}),
            192'({vq[i].g, vq[i].cs, vq[i].sa,
                  vq[i].rsp, vq[i].d0, vq[i].d1}));
      @(posedge clk);
      #1;
    end

    // reset mid OWN1 transfer, between edges
    {m0_cyc, m0_stb, s_ack, s_err} = 4'b0;
    m1_cyc = 1; m1_stb = 1;
    @(posedge clk);
    #2;
    check("own1_pre", 192'({gnt, s_cyc}),
          192'(3'b101));
    s_ack = 1; rst = 1;
    #1;
    check("rst_async", 192'({gnt, s_cyc, s_stb, m1_ack,
                             m1_err, to}),
          192'(0));
    @(posedge clk);
    #1;
    rst = 0; s_ack = 0;
    m0_cyc = 1; m0_stb = 1;
    @(posedge clk);
    #1;
    check("rst_tie", 192'({gnt, m1_ack}),
          192'(3'b010));
    {m0_cyc, m0_stb, m1_cyc, m1_stb} = 4'b0;
    @(posedge clk);
    #1;

    // randomized traffic vs model
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0; own = -1; last = 1; wcnt = 0;
    slow = 0;
    for (int k = 0; k < 3000; k++) begin
      if (k % 32 == 0) slow = ($urandom_range(0, 3) == 0);
      if (!m0_cyc) m0_cyc = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 9) == 0) m0_cyc = 0;
      if (!m1_cyc) m1_cyc = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 9) == 0) m1_cyc = 0;
      m0_stb = m0_cyc && ($urandom_range(0, 3) != 0);
      m1_stb = m1_cyc && ($urandom_range(0, 3) != 0);
      m0_we  = 1'($urandom);  m1_we  = 1'($urandom);
      m0_adr = $urandom;      m1_adr = $urandom;
      m0_dat = $urandom;      m1_dat = $urandom;
      m0_sel = 4'($urandom);  m1_sel = 4'($urandom);
      s_ack  = !slow && ($urandom_range(0, 2) == 0);
      s_err  = !slow && ($urandom_range(0, 15) == 0);
      s_dati = $urandom;
      @(negedge clk);
      model_eval(e);
      check($sformatf("rnd%0d", k), pk_act(), e);
      @(posedge clk);
      own = n_own; last = n_last; wcnt = n_wcnt;
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
